// File: rtl/streaming_dwc_pkg.sv
// streaming_dwc shared helpers.
// Width ratio, direction and counter-width derivation.
package streaming_dwc_pkg;

  function automatic bit dwc_upsize(input int in_w, input int out_w);
    return out_w > in_w;
  endfunction

  function automatic int dwc_ratio(input int in_w, input int out_w);
    if (out_w > in_w) return out_w / in_w;
    return in_w / out_w;
  endfunction

  function automatic bit dwc_legal(input int in_w, input int out_w);
    if (out_w > in_w) return (out_w % in_w) == 0;
    return (in_w % out_w) == 0;
  endfunction

  function automatic int cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/streaming_dwc_down.sv
// streaming_dwc downsize / pass-through path.
// Ports: in_* wide side, out_* narrow side, valid/ready handshake.
module streaming_dwc_down
  import streaming_dwc_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CW = cnt_w(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [IN_W-1:0] buf_q;
  logic [CW-1:0]   idx;
  logic            held;
  logic            last;
  logic            in_fire;
  logic            out_fire;

  assign last      = (idx == LAST);
  assign in_ready  = !held || (last && out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = held && out_ready;
  assign out_valid = held;
  // Buffer shifts down so slice idx always sits in the low bits.
  assign out_data  = buf_q[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      idx   <= '0;
      held  <= 1'b0;
    end else begin
      if (out_fire) begin
        idx   <= last ? '0 : idx + 1'b1;
        buf_q <= buf_q >> OUT_W;
        if (last) held <= 1'b0;
      end
      if (in_fire) begin
        buf_q <= in_data;
        held  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/streaming_dwc_up.sv
// streaming_dwc upsize path.
// Ports: in_* narrow side, out_* wide side, valid/ready handshake.
module streaming_dwc_up
  import streaming_dwc_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int RATIO = OUT_W / IN_W;
  localparam int CW = cnt_w(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [OUT_W-1:0] asm_q;
  logic [OUT_W-1:0] asm_full;
  logic [OUT_W-1:0] out_q;
  logic [CW-1:0]    cnt;
  logic             ov;
  logic             last;
  logic             in_fire;
  logic             out_fire;

  assign last      = (cnt == LAST);
  // Stall only when the completing slice would clobber a held word.
  assign in_ready  = !last || !ov || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = ov && out_ready;
  assign out_data  = out_q;
  assign out_valid = ov;

  always_comb begin
    asm_full = asm_q;
    asm_full[OUT_W-1 -: IN_W] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= '0;
      out_q <= '0;
      cnt   <= '0;
      ov    <= 1'b0;
    end else begin
      if (out_fire) ov <= 1'b0;
      if (in_fire) begin
        if (last) begin
          out_q <= asm_full;
          ov    <= 1'b1;
          cnt   <= '0;
        end else begin
          asm_q[int'(cnt)*IN_W +: IN_W] <= in_data;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/streaming_dwc.sv
// streaming_dwc: LSB-first AXI-Stream width converter.
// Ports: ap_clk/ap_rst_n, in0_V_V_* input stream, out_V_V_* output stream.
module streaming_dwc
  import streaming_dwc_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [IN_WIDTH-1:0]  in0_V_V_TDATA,
  input  logic                 in0_V_V_TVALID,
  output logic                 in0_V_V_TREADY,
  output logic [OUT_WIDTH-1:0] out_V_V_TDATA,
  output logic                 out_V_V_TVALID,
  input  logic                 out_V_V_TREADY
);

  localparam int RATIO  = dwc_ratio(IN_WIDTH, OUT_WIDTH);
  localparam bit UPSIZE = dwc_upsize(IN_WIDTH, OUT_WIDTH);

  if (!dwc_legal(IN_WIDTH, OUT_WIDTH)) begin : g_bad
    $error("streaming_dwc: widths %0d/%0d not integer multiples",
           IN_WIDTH, OUT_WIDTH);
  end

  if (UPSIZE) begin : g_up
    streaming_dwc_up #(
      .IN_W  (IN_WIDTH),
      .OUT_W (OUT_WIDTH)
    ) u_up (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .in_data   (in0_V_V_TDATA),
      .in_valid  (in0_V_V_TVALID),
      .in_ready  (in0_V_V_TREADY),
      .out_data  (out_V_V_TDATA),
      .out_valid (out_V_V_TVALID),
      .out_ready (out_V_V_TREADY)
    );
  end else begin : g_down
    streaming_dwc_down #(
      .IN_W  (IN_WIDTH),
      .OUT_W (OUT_WIDTH)
    ) u_down (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .in_data   (in0_V_V_TDATA),
      .in_valid  (in0_V_V_TVALID),
      .in_ready  (in0_V_V_TREADY),
      .out_data  (out_V_V_TDATA),
      .out_valid (out_V_V_TVALID),
      .out_ready (out_V_V_TREADY)
    );
  end

endmodule
